// File: rtl/bubble_pipe_ctrl.sv
// bubble_pipe_ctrl: in-order pipeline control. It has a fetch FSM with a
// one-entry skid hold, a data-access FSM that freezes the pipe while a memory
// op is outstanding, branch-redirect squashing and a saturating stall counter.
module bubble_pipe_ctrl #(
  parameter int STAGES         = 5,
  parameter int MEM_STAGE      = 3,
  parameter int REDIRECT_STAGE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_resp,
  input  logic              dmem_resp,
  input  logic              dmem_retry,
  input  logic              dmem_req,
  input  logic              redirect,
  output logic [STAGES-2:0] load_stage,
  output logic [STAGES-1:0] valid,
  output logic              imem_action_cyc,
  output logic              imem_action_stb,
  output logic              dmem_action_cyc,
  output logic              dmem_action_stb,
  output logic              fetch_buf_load,
  output logic              fetch_buf_sel,
  output logic [15:0]       stall_cycles
);

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_HOLD} fstate_t;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_RETRY} dstate_t;

  fstate_t             r_fstate, w_fstate_nxt;
  dstate_t             r_dstate, w_dstate_nxt;
  logic                r_drop, w_drop_nxt;
  logic [STAGES-1:1]   r_valid, w_valid_nxt;
  logic [15:0]         r_stall, w_stall_nxt;

  logic                w_valid0;
  logic                w_frozen;
  logic                w_redir_eff;
  logic                w_fbuf_load;

  // Hazard terms: fetch output usability, memory freeze, accepted redirect
  always_comb begin
    w_valid0    = ((r_fstate == F_REQ) && imem_resp && !r_drop) || (r_fstate == F_HOLD);
    w_frozen    = r_valid[MEM_STAGE] && dmem_req && !((r_dstate == D_REQ) && dmem_resp);
    w_redir_eff = redirect && r_valid[REDIRECT_STAGE] && !w_frozen;
  end

  // Fetch FSM next state; a response arriving during a freeze is parked in the skid register
  always_comb begin
    w_fstate_nxt = r_fstate;
    w_drop_nxt   = r_drop;
    w_fbuf_load  = 1'b0;
    case (r_fstate)
      F_IDLE: w_fstate_nxt = F_REQ;
      F_REQ: begin
        if (imem_resp) begin
          if (r_drop) begin
            // response belongs to the squashed path
            w_drop_nxt = 1'b0;
          end else if (w_frozen) begin
            w_fbuf_load  = 1'b1;
            w_fstate_nxt = F_HOLD;
          end
        end else if (w_redir_eff) begin
          // outstanding fetch is now on the wrong path
          w_drop_nxt = 1'b1;
        end
      end
      F_HOLD: begin
        if (w_redir_eff || !w_frozen) w_fstate_nxt = F_REQ;
      end
      default: w_fstate_nxt = F_IDLE;
    endcase
  end

  // Data FSM next state; a response beats a simultaneous retry
  always_comb begin
    w_dstate_nxt = r_dstate;
    case (r_dstate)
      D_IDLE:  if (r_valid[MEM_STAGE] && dmem_req) w_dstate_nxt = D_REQ;
      D_REQ: begin
        if (dmem_resp)       w_dstate_nxt = D_IDLE;
        else if (dmem_retry) w_dstate_nxt = D_RETRY;
      end
      D_RETRY: w_dstate_nxt = D_REQ;
      default: w_dstate_nxt = D_IDLE;
    endcase
  end

  // Valid shift with redirect squash of the younger stages; everything holds while frozen
  always_comb begin
    w_valid_nxt = r_valid;
    if (!w_frozen) begin
      for (int i = 2; i < STAGES; i++) begin
        w_valid_nxt[i] = r_valid[i-1];
      end
      w_valid_nxt[1] = w_valid0 && !w_redir_eff;
      if (w_redir_eff) begin
        for (int i = 1; i <= REDIRECT_STAGE; i++) begin
          w_valid_nxt[i] = 1'b0;
        end
      end
    end
  end

  // Saturating stall counter
  always_comb begin
    w_stall_nxt = r_stall;
    if ((w_frozen || !w_valid0) && (r_stall != 16'hFFFF)) w_stall_nxt = r_stall + 16'd1;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fstate <= F_IDLE;
      r_dstate <= D_IDLE;
      r_drop   <= 1'b0;
      r_valid  <= '0;
      r_stall  <= 16'd0;
    end else begin
      r_fstate <= w_fstate_nxt;
      r_dstate <= w_dstate_nxt;
      r_drop   <= w_drop_nxt;
      r_valid  <= w_valid_nxt;
      r_stall  <= w_stall_nxt;
    end
  end

  // Outputs are forced quiet for the whole time reset is asserted
  always_comb begin
    valid           = reset ? '0 : {r_valid, w_valid0};
    load_stage      = (reset || w_frozen) ? '0 : '1;
    imem_action_cyc = !reset && (r_fstate == F_REQ);
    imem_action_stb = !reset && (r_fstate == F_REQ);
    dmem_action_cyc = !reset && (r_dstate != D_IDLE);
    dmem_action_stb = !reset && (r_dstate == D_REQ);
    fetch_buf_load  = !reset && w_fbuf_load;
    fetch_buf_sel   = !reset && (r_fstate == F_HOLD);
    stall_cycles    = reset ? 16'd0 : r_stall;
  end

endmodule
